// File: rtl/updi_pkg.sv
// Shared definitions for the UPDI PHY arbiter slice.
// Holds the arbiter FSM state type and the number of clients sharing one PHY.
package updi_pkg;

  localparam int unsigned NumClients = 2;

  typedef enum logic [1:0] {
    StIdle,
    StOwned,
    StBrkWait,
    StFlush
  } arb_state_e;

endpackage

// File: rtl/updi_activity_timer.sv
// Owner inactivity counter.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   clr       - zero the count (new session or owner activity)
//   en        - count this cycle (only while a session is owned)
//   expired   - count has reached Limit-1
// The count saturates at all-ones instead of wrapping.
module updi_activity_timer #(
  parameter int unsigned Limit = 5000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(Limit) + 1;

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/updi_phy_arbiter.sv
// Two-client arbiter in front of a single UPDI PHY.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   req, gnt, timeout   - per-client session request, registered grant, inactivity revoke pulse
//   cli_*               - client-side FIFO / double-break view, muxed to the current owner
//   uart_*, double_*    - PHY-side FIFO and double-break interface
// A session is granted round-robin, routed exclusively to its owner, and on release (or
// inactivity timeout) waits for any double break to finish and drains the PHY RX FIFO so the
// next owner starts clean.
module updi_phy_arbiter
  import updi_pkg::*;
#(
  parameter int unsigned IDLE_TIMEOUT_CLKS = 5000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NumClients-1:0]     req,
  output logic [NumClients-1:0]     gnt,
  output logic [NumClients-1:0]     timeout,
  input  logic [8*NumClients-1:0]   cli_tx_data,
  input  logic [NumClients-1:0]     cli_tx_wr_en,
  output logic [NumClients-1:0]     cli_tx_full,
  output logic [7:0]                cli_rx_data,
  input  logic [NumClients-1:0]     cli_rx_rd_en,
  output logic [NumClients-1:0]     cli_rx_empty,
  input  logic [NumClients-1:0]     cli_dbl_start,
  output logic [NumClients-1:0]     cli_dbl_busy,
  output logic [NumClients-1:0]     cli_dbl_done,
  output logic [7:0]                uart_tx_fifo_data_in,
  output logic                      uart_tx_fifo_wr_en,
  input  logic                      uart_tx_fifo_full,
  input  logic [7:0]                uart_rx_fifo_data_out,
  output logic                      uart_rx_fifo_rd_en,
  input  logic                      uart_rx_fifo_empty,
  output logic                      double_break_start,
  input  logic                      double_break_busy,
  input  logic                      double_break_done
);

  arb_state_e            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;     // client served most recently
  logic [NumClients-1:0] gnt_q, gnt_d;
  logic [NumClients-1:0] inelig_q, inelig_d; // timed out, waiting for req to drop
  logic [NumClients-1:0] elig;
  logic                  owned, owner_act, expired, fire, timer_clr;

  assign owned = (state_q == StOwned);
  assign elig  = req & ~inelig_q;
  assign gnt   = gnt_q;

  assign owner_act = owned && (cli_tx_wr_en[owner_q] || cli_rx_rd_en[owner_q] ||
                               cli_dbl_start[owner_q]);
  // A release in the same cycle wins over the timeout.
  assign fire = owned && expired && req[owner_q];

  updi_activity_timer #(
    .Limit (IDLE_TIMEOUT_CLKS)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (timer_clr),
    .en      (owned),
    .expired (expired)
  );

  // Data path: only the owner, and only while OWNED, sees the PHY.
  always_comb begin
    uart_tx_fifo_data_in = '0;
    uart_tx_fifo_wr_en   = 1'b0;
    uart_rx_fifo_rd_en   = 1'b0;
    double_break_start   = 1'b0;
    cli_tx_full          = '1;
    cli_rx_empty         = '1;
    cli_dbl_busy         = '0;
    cli_dbl_done         = '0;
    timeout              = '0;
    if (owned) begin
      uart_tx_fifo_data_in  = cli_tx_data[{owner_q, 3'b000} +: 8];
      uart_tx_fifo_wr_en    = cli_tx_wr_en[owner_q];
      uart_rx_fifo_rd_en    = cli_rx_rd_en[owner_q];
      double_break_start    = cli_dbl_start[owner_q];
      cli_tx_full[owner_q]  = uart_tx_fifo_full;
      cli_rx_empty[owner_q] = uart_rx_fifo_empty;
      cli_dbl_busy[owner_q] = double_break_busy;
      cli_dbl_done[owner_q] = double_break_done;
      if (fire) begin
        timeout[owner_q] = 1'b1;
      end
    end else if (state_q == StFlush) begin
      // Drain and discard stale RX bytes left by the previous owner.
      uart_rx_fifo_rd_en = !uart_rx_fifo_empty;
    end
  end

  assign cli_rx_data = uart_rx_fifo_data_out;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    inelig_d  = inelig_q & req;
    timer_clr = owner_act || double_break_busy;
    case (state_q)
      StIdle: begin
        if (|elig) begin
          owner_d          = (&elig) ? ~last_q : elig[1];
          state_d          = StOwned;
          gnt_d            = '0;
          gnt_d[owner_d]   = 1'b1;
          timer_clr        = 1'b1;
        end
      end
      StOwned: begin
        if (!req[owner_q] || fire) begin
          gnt_d   = '0;
          state_d = double_break_busy ? StBrkWait : StFlush;
          if (fire) begin
            inelig_d[owner_q] = 1'b1;
          end
        end
      end
      StBrkWait: begin
        if (!double_break_busy) begin
          state_d = StFlush;
        end
      end
      StFlush: begin
        if (uart_rx_fifo_empty) begin
          state_d = StIdle;
          last_d  = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1; // pretend client 1 went last so client 0 wins first
      gnt_q    <= '0;
      inelig_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      inelig_q <= inelig_d;
    end
  end

endmodule

// File: tb/tb_updi_phy_arbiter.sv
// Bench for updi_phy_arbiter: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural session model.
module tb_updi_phy_arbiter;

  localparam int T = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req, gnt, timeout;
  logic [15:0] cli_tx_data;
  logic [1:0]  cli_tx_wr_en, cli_tx_full, cli_rx_rd_en, cli_rx_empty;
  logic [7:0]  cli_rx_data;
  logic [1:0]  cli_dbl_start, cli_dbl_busy, cli_dbl_done;
  logic [7:0]  uart_tx_fifo_data_in, uart_rx_fifo_data_out;
  logic        uart_tx_fifo_wr_en, uart_tx_fifo_full, uart_rx_fifo_rd_en, uart_rx_fifo_empty;
  logic        double_break_start, double_break_busy, double_break_done;

  always #5 clk = ~clk;

  updi_phy_arbiter #(
    .IDLE_TIMEOUT_CLKS (T)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .req                   (req),
    .gnt                   (gnt),
    .timeout               (timeout),
    .cli_tx_data           (cli_tx_data),
    .cli_tx_wr_en          (cli_tx_wr_en),
    .cli_tx_full           (cli_tx_full),
    .cli_rx_data           (cli_rx_data),
    .cli_rx_rd_en          (cli_rx_rd_en),
    .cli_rx_empty          (cli_rx_empty),
    .cli_dbl_start         (cli_dbl_start),
    .cli_dbl_busy          (cli_dbl_busy),
    .cli_dbl_done          (cli_dbl_done),
    .uart_tx_fifo_data_in  (uart_tx_fifo_data_in),
    .uart_tx_fifo_wr_en    (uart_tx_fifo_wr_en),
    .uart_tx_fifo_full     (uart_tx_fifo_full),
    .uart_rx_fifo_data_out (uart_rx_fifo_data_out),
    .uart_rx_fifo_rd_en    (uart_rx_fifo_rd_en),
    .uart_rx_fifo_empty    (uart_rx_fifo_empty),
    .double_break_start    (double_break_start),
    .double_break_busy     (double_break_busy),
    .double_break_done     (double_break_done)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Session model: phase 0 free, 1 held by m_owner, 2 waiting on break, 3 draining RX.
  int         m_phase = 0;
  int         m_owner = 0;
  int         m_quiet = 0;  // consecutive held cycles with no owner activity
  int         m_last  = 1;
  logic [1:0] m_blocked = 2'b00;
  bit         m_valid = 1'b0;

  int rx_count = 0;
  bit rd_cap   = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_cycle();
    logic [1:0] e_gnt, e_to, e_full, e_empty, e_busy, e_done;
    logic       e_wr, e_rd, e_dbl;
    logic [7:0] e_data;
    bit         act;
    int         o;
    o      = m_owner;
    rd_cap = uart_rx_fifo_rd_en;
    if (m_valid) begin
      e_gnt = '0; e_to = '0; e_full = '1; e_empty = '1; e_busy = '0; e_done = '0;
      e_wr = 1'b0; e_rd = 1'b0; e_dbl = 1'b0; e_data = '0;
      if (m_phase == 1) begin
        e_gnt[o]   = 1'b1;
        e_to[o]    = (m_quiet == T - 1) && req[o];
        e_full[o]  = uart_tx_fifo_full;
        e_empty[o] = uart_rx_fifo_empty;
        e_busy[o]  = double_break_busy;
        e_done[o]  = double_break_done;
        e_wr       = cli_tx_wr_en[o];
        e_rd       = cli_rx_rd_en[o];
        e_dbl      = cli_dbl_start[o];
        e_data     = cli_tx_data[o*8 +: 8];
      end else if (m_phase == 3) begin
        e_rd = !uart_rx_fifo_empty;
      end
      chk("gnt", 16'(gnt), 16'(e_gnt));
      chk("timeout", 16'(timeout), 16'(e_to));
      chk("phy_strobes", 16'({uart_tx_fifo_wr_en, uart_rx_fifo_rd_en, double_break_start}),
          16'({e_wr, e_rd, e_dbl}));
      if (e_wr) chk("tx_data", 16'(uart_tx_fifo_data_in), 16'(e_data));
      chk("client_view", {cli_tx_full, cli_rx_empty, cli_dbl_busy, cli_dbl_done, 8'h00},
          {e_full, e_empty, e_busy, e_done, 8'h00});
      chk("rx_data", 16'(cli_rx_data), 16'(uart_rx_fifo_data_out));
    end
    if (rst) begin
      m_phase = 0; m_quiet = 0; m_last = 1; m_blocked = 2'b00; m_owner = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      for (int i = 0; i < 2; i++) if (!req[i]) m_blocked[i] = 1'b0;
      case (m_phase)
        0: begin
          if ((req[0] && !m_blocked[0]) || (req[1] && !m_blocked[1])) begin
            if (req[0] && !m_blocked[0] && req[1] && !m_blocked[1]) m_owner = 1 - m_last;
            else m_owner = (req[0] && !m_blocked[0]) ? 0 : 1;
            m_phase = 1;
            m_quiet = 0;
          end
        end
        1: begin
          act = cli_tx_wr_en[o] || cli_rx_rd_en[o] || cli_dbl_start[o] || double_break_busy;
          if (!req[o]) begin
            m_phase = double_break_busy ? 2 : 3;
          end else if (m_quiet == T - 1) begin
            m_blocked[o] = 1'b1;
            m_phase = double_break_busy ? 2 : 3;
          end else begin
            m_quiet = act ? 0 : m_quiet + 1;
          end
        end
        2: if (!double_break_busy) m_phase = 3;
        default: begin
          if (uart_rx_fifo_empty) begin
            m_phase = 0;
            m_last  = m_owner;
          end
        end
      endcase
    end
  endtask

  task automatic set_rx(input int n);
    rx_count           = n;
    uart_rx_fifo_empty = (n == 0);
  endtask

  // One clock: check and advance at the falling edge, then return just after the rising edge
  // with the PHY RX FIFO occupancy updated.
  task automatic tick();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    if (rst) rx_count = 0;
    else if (rd_cap && rx_count > 0) rx_count--;
    uart_rx_fifo_empty    = (rx_count == 0);
    uart_rx_fifo_data_out = 8'($urandom);
  endtask

  initial begin
    int nrd, k_to;
    bit quiet_regime;
    rst = 1'b1; req = '0; cli_tx_data = '0; cli_tx_wr_en = '0; cli_rx_rd_en = '0;
    cli_dbl_start = '0; uart_tx_fifo_full = 1'b0; uart_rx_fifo_data_out = '0;
    uart_rx_fifo_empty = 1'b1; double_break_busy = 1'b0; double_break_done = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("reset_gnt", 16'(gnt), 16'h0);
    chk("reset_timeout", 16'(timeout), 16'h0);
    chk("reset_views", 16'({cli_tx_full, cli_rx_empty, cli_dbl_busy, cli_dbl_done}), 16'h00f0);
    chk("reset_phy", 16'({uart_tx_fifo_wr_en, uart_rx_fifo_rd_en, double_break_start}), 16'h0);

    // Single requester, one-cycle grant latency, owner write, non-owner isolation.
    repeat (9) tick();
    req = 2'b01;
    #1 chk("gnt_before_edge", 16'(gnt), 16'h0);
    tick();
    #1 chk("gnt_latency", 16'(gnt), 16'h1);
    cli_tx_data = 16'hAA55; cli_tx_wr_en = 2'b11;
    #1 chk("owner_write", 16'({uart_tx_fifo_wr_en, uart_tx_fifo_data_in}), 16'h155);
    chk("nonowner_full", 16'(cli_tx_full[1]), 16'h1);
    tick();
    cli_tx_wr_en = 2'b10;
    #1 chk("nonowner_write_blocked", 16'(uart_tx_fifo_wr_en), 16'h0);
    tick();
    cli_tx_wr_en = 2'b00;

    // Release with three stale RX bytes: exactly three drain reads.
    set_rx(3);
    req = 2'b00;
    tick();
    nrd = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rd_cap) nrd++;
    end
    chk("flush_reads", 16'(nrd), 16'd3);
    req = 2'b10;
    tick();
    #1 chk("next_owner_gnt", 16'(gnt), 16'h2);
    chk("next_owner_rx_empty", 16'(cli_rx_empty), 16'h3);
    req = 2'b00;
    repeat (3) tick();

    // Simultaneous requests after reset: client 0 first, then client 1.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    req = 2'b11;
    tick();
    #1 chk("rr_first", 16'(gnt), 16'h1);
    req = 2'b10;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      if (gnt == 2'b10) break;
    end
    chk("rr_second", 16'(gnt), 16'h2);
    req = 2'b00;
    repeat (3) tick();

    // Inactivity timeout and re-eligibility only after req drops.
    req = 2'b01;
    tick();
    k_to = -1;
    for (int k = 0; k < 150; k++) begin
      #1;
      if (timeout[0]) begin
        k_to = k;
        break;
      end
      tick();
    end
    chk("timeout_cycle", 16'(k_to), 16'd99);
    for (int i = 0; i < 20; i++) begin
      tick();
      #1 chk("no_regrant_while_held", 16'(gnt), 16'h0);
    end
    req = 2'b00;
    tick();
    req = 2'b01;
    tick();
    #1 chk("regrant_after_drop", 16'(gnt), 16'h1);
    req = 2'b00;
    repeat (3) tick();

    // Release during a double break: nobody granted until busy falls and drain completes.
    req = 2'b01;
    tick();
    double_break_busy = 1'b1;
    req = 2'b10;
    tick();
    for (int i = 0; i < 20; i++) begin
      #1 chk("brk_hold", 16'(gnt), 16'h0);
      tick();
    end
    double_break_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      if (gnt == 2'b10) break;
    end
    chk("brk_then_grant", 16'(gnt), 16'h2);
    req = 2'b00;
    repeat (3) tick();

    // Randomized traffic, alternating busy and near-silent regimes so timeouts occur.
    for (int c = 0; c < 4000; c++) begin
      quiet_regime = ((c / 500) % 2) == 1;
      for (int i = 0; i < 2; i++) if ($urandom_range(0, 149) == 0) req[i] = ~req[i];
      for (int i = 0; i < 2; i++) begin
        cli_tx_wr_en[i]  = quiet_regime ? ($urandom_range(0, 999) == 0) : ($urandom_range(0, 99) < 4);
        cli_rx_rd_en[i]  = quiet_regime ? 1'b0 : ($urandom_range(0, 99) < 3);
        cli_dbl_start[i] = quiet_regime ? 1'b0 : ($urandom_range(0, 99) < 1);
      end
      cli_tx_data       = 16'($urandom);
      uart_tx_fifo_full = ($urandom_range(0, 3) == 0);
      double_break_done = ($urandom_range(0, 7) == 0);
      if (double_break_busy) double_break_busy = ($urandom_range(0, 9) != 0);
      else double_break_busy = !quiet_regime && ($urandom_range(0, 79) == 0);
      if (rx_count == 0 && $urandom_range(0, 19) == 0) set_rx($urandom_range(1, 4));
      rst = ($urandom_range(0, 1999) == 0);
      tick();
    end
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
